// File: rtl/button_input.sv
// Push-button reader: synchronizes, debounces and classifies a raw pad
// into a clean level, press/release/short/long strobes and a press count.
module button_input #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 25000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk_25m,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESSED,
    LONG_HELD
  } state_t;

  logic          raw;
  logic          s1;
  logic          s2;
  logic [DW-1:0] db_cnt;
  logic          db_done;
  logic          press_evt;
  logic          rel_evt;

  state_t        state_q;
  state_t        state_d;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic [7:0]    count_d;
  logic          press_d;
  logic          rel_d;
  logic          short_d;
  logic          long_d;

  assign raw = ACTIVE_LOW ? ~btn_in : btn_in;

  // Toggle on the edge where the run of disagreeing samples reaches the limit
  assign db_done   = (s2 != btn_level) && (db_cnt == DB_LAST);
  assign press_evt = db_done & ~btn_level;
  assign rel_evt   = db_done &  btn_level;

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == btn_level) begin
        db_cnt <= '0;
      end else if (db_done) begin
        db_cnt    <= '0;
        btn_level <= ~btn_level;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q       <= RELEASED;
      hold_q        <= '0;
      press_count   <= 8'd0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      press_count   <= count_d;
      press_pulse   <= press_d;
      release_pulse <= rel_d;
      short_pulse   <= short_d;
      long_pulse    <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    count_d = press_count;
    press_d = 1'b0;
    rel_d   = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (press_evt) begin
          state_d = PRESSED;
          hold_d  = '0;
          press_d = 1'b1;
          count_d = press_count + 8'd1;
        end
      end
      PRESSED: begin
        // A release on the threshold edge still counts as short
        if (rel_evt) begin
          state_d = RELEASED;
          rel_d   = 1'b1;
          short_d = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      LONG_HELD: begin
        if (rel_evt) begin
          state_d = RELEASED;
          rel_d   = 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

endmodule

// File: tb/tb_button_input.sv
// Randomized scoreboard bench for button_input with a timestamp-based
// reference model of debounce and press classification.
module tb_button_input;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic       clk;
  logic       rst;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  button_input #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk_25m      (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // kind bits: {press, long, release, short}
  typedef struct {
    int         at;
    logic [3:0] kind;
  } ev_t;

  ev_t q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic       m_s1;
  logic       m_s2;
  logic       m_level;
  logic       m_pressed;
  logic [7:0] m_count;
  int         last_agree;
  int         press_at;

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, expected %h",
               nm, cyc, got, exp);
    end
  endtask

  // Reference: a level flips once DEB consecutive synchronized samples
  // disagree with it; press classification is by elapsed edges.
  always @(posedge clk) begin
    logic toggled;
    cyc++;
    toggled = 1'b0;
    if (rst) begin
      m_s1       = 1'b0;
      m_s2       = 1'b0;
      m_level    = 1'b0;
      m_pressed  = 1'b0;
      m_count    = 8'd0;
      last_agree = cyc;
    end else begin
      if (m_s2 == m_level) begin
        last_agree = cyc;
      end else if (cyc - last_agree == DEB) begin
        toggled    = 1'b1;
        m_level    = ~m_level;
        last_agree = cyc;
        if (m_level) begin
          m_count   = m_count + 8'd1;
          m_pressed = 1'b1;
          press_at  = cyc;
          q.push_back('{at: cyc, kind: 4'b1000});
        end else begin
          m_pressed = 1'b0;
          if (cyc - press_at <= LONG)
            q.push_back('{at: cyc, kind: 4'b0011});
          else
            q.push_back('{at: cyc, kind: 4'b0010});
        end
      end
      if (!toggled && m_pressed && (cyc - press_at == LONG))
        q.push_back('{at: cyc, kind: 4'b0100});
      m_s2 = m_s1;
      m_s1 = ~btn_in;
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp;
    logic [3:0] got;
    if (cyc > 0) begin
      exp = 4'b0000;
      while (q.size() > 0 && q[0].at < cyc) begin
        chk("stale_event", {4'b0, q[0].kind}, 8'h00);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].at == cyc) begin
        exp = q[0].kind;
        void'(q.pop_front());
      end
      got = {press_pulse, long_pulse, release_pulse, short_pulse};
      chk("pulses", {4'b0, got}, {4'b0, exp});
      chk("btn_level", {7'b0, btn_level}, {7'b0, m_level});
      chk("press_count", press_count, m_count);
    end
  end

  task automatic hold(input logic v, input int n);
    btn_in = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 6);

    // clean short press
    hold(1'b0, 10);
    hold(1'b1, 10);

    // bounce on press
    hold(1'b0, 3);
    hold(1'b1, 1);
    hold(1'b0, 3);
    hold(1'b1, 1);
    hold(1'b0, 10);
    hold(1'b1, 10);

    // long press
    hold(1'b0, 40);
    hold(1'b1, 10);

    // release around the long threshold
    for (int k = 19; k <= 21; k++) begin
      hold(1'b0, k);
      hold(1'b1, 12);
    end

    // random bouncy traffic
    for (int i = 0; i < 60; i++)
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 30));
    hold(1'b1, 12);

    // counter wrap
    for (int i = 0; i < 256; i++) begin
      hold(1'b0, 6);
      hold(1'b1, 6);
    end

    // reset in the middle of a held press
    hold(1'b0, 10);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(1'b0, 15);
    hold(1'b1, 12);

    hold(1'b1, 10);
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/button_input.md
# button_input

Debounced push-button reader for the iCESugar-Pro. The raw pad comes in as an asynchronous input and is synchronized, debounced and classified. The block emits a clean level, single-cycle press/release events, short/long-press events and a wrapping press counter. It is the input-side counterpart to the LED drivers: user controls such as mode select and FFT freeze enter the design here, and LED-driving logic consumes the outputs.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable samples required to accept a level change (10 ms at 25 MHz); must be ≥1.
- `LONG_CYCLES`, default 25000000: cycles a press must be held to count as long (1 s); must be ≥1.
- `ACTIVE_LOW`, default 1: 1 means a pressed button drives the pad to 0.
- `clk_25m` in 1: 25 MHz system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_in` in 1: raw button pad; asynchronous and bouncy.
- `btn_level` out 1: debounced state; 1 = pressed.
- `press_pulse` out 1: one-cycle strobe on a debounced press.
- `release_pulse` out 1: one-cycle strobe on a debounced release.
- `short_pulse` out 1: one-cycle strobe on a release that ends a press that never became long.
- `long_pulse` out 1: one-cycle strobe when a held press reaches `LONG_CYCLES`.
- `press_count` out 8: number of debounced presses, modulo 256.

## Operation
- **Polarity.** Normalize first: `raw = ACTIVE_LOW ? ~btn_in : btn_in`, so 1 = pressed everywhere downstream.
- **Synchronizer.** Two flops, s1 then s2. Both reset to 0 (released).
- **Debounce counter.**
  - Width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - On each edge: if s2 == `btn_level`, the counter clears to 0; otherwise it increments.
  - On the edge where the count would reach `DEBOUNCE_CYCLES`, `btn_level` toggles and the counter clears.
  - Any single sample equal to `btn_level` restarts the count.
- **Classifier FSM.** States are RELEASED, PRESSED, LONG_HELD.
  - RELEASED → PRESSED on a debounced press. Assert `press_pulse`, clear the hold counter, increment `press_count`.
  - PRESSED: the hold counter increments each edge. When it reaches `LONG_CYCLES`, assert `long_pulse` and go to LONG_HELD.
  - PRESSED → RELEASED on a debounced release. Assert `release_pulse` and `short_pulse` in the same cycle.
  - LONG_HELD → RELEASED on a debounced release. Assert `release_pulse` only.
  - Hold counter width is `$clog2(LONG_CYCLES+1)`. It is not advanced outside PRESSED.
- **Simultaneous release and long threshold.** If a debounced release lands on the same edge the hold counter would reach `LONG_CYCLES`, release wins. Outputs are `release_pulse` + `short_pulse`, with no `long_pulse`.
- **Press counter.** `press_count` wraps 255 → 0 and is never saturated.
- **Pulse exclusivity.** At most one of press/long/release fires per cycle. `short_pulse` only ever fires together with `release_pulse`.
- **Reset.**
  - Values: s1, s2, both counters, `btn_level`, all pulses and `press_count` = 0; FSM = RELEASED.
  - Reset mid-press abandons the press with no release or short pulse.
  - A button still held when reset deasserts is detected as a new press after the normal latency.

## Timing
- Latency convention: edge 0 is the first edge that samples the new normalized pad level.
  - s1 is updated at edge 0; s2 at edge 1.
  - `btn_level` changes at edge `DEBOUNCE_CYCLES+1`.
- `press_pulse` and `release_pulse` are registered and rise on the same edge as the `btn_level` change. Each is high for exactly one cycle.
- `press_count` updates on the same edge as `press_pulse`.
- `long_pulse` rises exactly `LONG_CYCLES` edges after the edge that raised `press_pulse`.
- There is no combinational path from `btn_in` to any output.

## Test plan
All tests use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `ACTIVE_LOW`=1.
- **Reset.** Hold `rst`=1 for 3 cycles with `btn_in`=1 → all outputs 0 and `press_count`=0 during reset and after it.
- **Clean press.** Step `btn_in` 1→0 and hold → `btn_level` and `press_pulse` rise at edge 5. `press_pulse` is high for 1 cycle; `press_count`=1.
- **Bounce rejection.** Drive `btn_in` low 3 cycles, high 1, low 3, high 1, then low steady → exactly one `press_pulse`, at edge 5 of the steady-low run.
- **Short press.** Hold pressed 10 cycles, then release cleanly → `release_pulse` and `short_pulse` high together for one cycle; `long_pulse` never asserted.
- **Long press and boundary.**
  - Hold pressed 40 cycles → `long_pulse` exactly 20 cycles after `press_pulse`. The later release gives `release_pulse` only.
  - Time the release so debounce completes on the 20th hold edge → short, not long.
- **Wrap and reset mid-press.**
  - 256 clean presses → `press_count` returns to 0.
  - Assert `rst` during a held press → outputs clear with no pulses. After `rst` deasserts with the button still held, `press_pulse` occurs at edge 5.
